// File: rtl/rv_imem_loader_if.sv
// Stream-in / imem-write bundle for rv_imem_loader.
//   AW          : imem word-address width
//   s_valid     : byte valid (source -> loader)
//   s_ready     : loader can accept a byte (loader -> source)
//   s_data[7:0] : program byte
//   s_last      : final byte of the program, qualified by s_valid
//   imem_we     : one-cycle word write strobe (loader -> imem)
//   imem_addr   : word index of the write
//   imem_wdata  : 32-bit little-endian word written
// Modports: master = byte source / imem side, slave = the loader.
interface rv_imem_loader_if #(
  parameter int AW = 6
);
  logic          s_valid;
  logic          s_ready;
  logic [7:0]    s_data;
  logic          s_last;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;

  modport master (
    output s_valid, s_data, s_last,
    input  s_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  s_valid, s_data, s_last,
    output s_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/rv_imem_loader.sv
// Boot-time program loader for rvsingle_top.
// Packs a valid/ready byte stream into little-endian 32-bit words, writes
// them into the core's instruction memory, and holds the core in reset until
// the load is complete.
// Ports:
//   clk          : clock, all state updates on the rising edge
//   reset        : synchronous active-low reset (0 = reset)
//   bus          : rv_imem_loader_if.slave (byte stream in, imem write out)
//   core_reset   : active-high reset to rvsingle_top
//   done         : load complete, core running
//   err          : image overflow (or checksum mismatch when enabled)
// Optional build macro RV_IMEM_LOADER_CHECKSUM_EN adds:
//   exp_checksum : expected mod-2^32 sum of all written words
//   checksum     : running mod-2^32 sum of written words
// Parameters:
//   AW           : imem word-address width (capacity 2^AW words)
//   HOLD_CYCLES  : cycles core_reset stays high after the final write (1..255)
module rv_imem_loader #(
  parameter int AW          = 6,
  parameter int HOLD_CYCLES = 2
) (
  input  logic                clk,
  input  logic                reset,
  rv_imem_loader_if.slave     bus,
`ifdef RV_IMEM_LOADER_CHECKSUM_EN
  input  logic [31:0]         exp_checksum,
  output logic [31:0]         checksum,
`endif
  output logic                core_reset,
  output logic                done,
  output logic                err
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    HOLD,
    RUN,
    ERROR
  } state_t;

  state_t        state;
  logic [1:0]    byte_cnt;
  logic [AW-1:0] word_cnt;
  logic [7:0]    hold_cnt;
  logic [31:0]   asm_q;

  logic          accept;
  logic          word_end;
  logic          word_full;
  logic [31:0]   word_nxt;

  always_comb begin
    accept    = (state == LOAD) && bus.s_valid && bus.s_ready;
    word_end  = (byte_cnt == 2'd3) || bus.s_last;
    word_full = &word_cnt;
    // asm_q is cleared after every word, so lanes above byte_cnt stay zero
    // and a short final word is zero-padded for free.
    word_nxt  = asm_q | ({24'b0, bus.s_data} << {byte_cnt, 3'b000});
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state          <= IDLE;
      byte_cnt       <= '0;
      word_cnt       <= '0;
      hold_cnt       <= '0;
      asm_q          <= '0;
      bus.s_ready    <= 1'b0;
      bus.imem_we    <= 1'b0;
      bus.imem_addr  <= '0;
      bus.imem_wdata <= '0;
      core_reset     <= 1'b1;
      done           <= 1'b0;
      err            <= 1'b0;
`ifdef RV_IMEM_LOADER_CHECKSUM_EN
      checksum       <= '0;
`endif
    end else begin
      bus.imem_we <= 1'b0;
      case (state)
        IDLE: begin
          state       <= LOAD;
          bus.s_ready <= 1'b1;
        end

        LOAD: begin
          if (accept) begin
            if (word_end) begin
              bus.imem_we    <= 1'b1;
              bus.imem_addr  <= word_cnt;
              bus.imem_wdata <= word_nxt;
              word_cnt       <= word_cnt + AW'(1);
              byte_cnt       <= '0;
              asm_q          <= '0;
`ifdef RV_IMEM_LOADER_CHECKSUM_EN
              checksum       <= checksum + word_nxt;
`endif
              // s_last wins over the full check, so an image that exactly
              // fills imem is accepted.
              if (bus.s_last) begin
                state       <= HOLD;
                bus.s_ready <= 1'b0;
              end else if (word_full) begin
                state       <= ERROR;
                bus.s_ready <= 1'b0;
                err         <= 1'b1;
              end
            end else begin
              asm_q    <= word_nxt;
              byte_cnt <= byte_cnt + 2'd1;
            end
          end
        end

        HOLD: begin
          // Entered on the final write edge; leaving on the HOLD_CYCLES-th
          // edge after it.
          if (hold_cnt == 8'(HOLD_CYCLES - 1)) begin
`ifdef RV_IMEM_LOADER_CHECKSUM_EN
            if (checksum == exp_checksum) begin
              state      <= RUN;
              core_reset <= 1'b0;
              done       <= 1'b1;
            end else begin
              state      <= ERROR;
              err        <= 1'b1;
            end
`else
            state      <= RUN;
            core_reset <= 1'b0;
            done       <= 1'b1;
`endif
          end else begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end

        RUN: begin
          state <= RUN;
        end

        ERROR: begin
          state <= ERROR;
        end

        default: begin
          state       <= ERROR;
          bus.s_ready <= 1'b0;
          core_reset  <= 1'b1;
          done        <= 1'b0;
          err         <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/rv_imem_loader.md
Name:
rv_imem_loader

Overview:
- Boot-time program loader sitting directly upstream of rvsingle_top.
- Accepts a byte stream over a valid/ready handshake and packs it into little-endian 32-bit words.
- Writes those words into the core's instruction-memory write port.
- Holds the core in reset until loading finishes, then releases it. This replaces the fixed-image memory initialisation with a bench- or host-driven load.

Parameters:
- AW, 6, imem word-address width; capacity = 2^AW words.
- HOLD_CYCLES, 2, cycles core_reset stays high after the final word write; range 1..255.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset (sampled on rising clk edge; 0 = reset).
- s_valid  input  1  byte valid.
- s_ready  output  1  loader can accept a byte.
- s_data  input  8  program byte.
- s_last  input  1  marks the final byte of the program; qualified by s_valid.
- imem_we  output  1  one-cycle word write strobe to instruction memory.
- imem_addr  output  AW  word index of the write.
- imem_wdata  output  32  word written.
- core_reset  output  1  active-high reset to rvsingle_top.
- done  output  1  load complete, core running.
- err  output  1  overflow (or checksum failure, see Optional Feature).

Behaviour:
- Reset (reset==0 at edge):
  - State IDLE; byte_cnt=0, word_cnt=0, hold_cnt=0, assembly register=0.
  - Outputs: s_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, core_reset=1, done=0, err=0.
- Reset mid-operation: same values on the next edge; partial words are discarded; previously written imem contents are untouched.
- States: IDLE, LOAD, HOLD, RUN, ERROR. All outputs are registered.
- IDLE: unconditionally -> LOAD on the first edge with reset==1.
- LOAD:
  - s_ready=1.
  - Byte accepted on an edge with s_valid & s_ready. Lane = byte_cnt (lane0 -> bits 7:0, lane3 -> bits 31:24); byte_cnt increments mod 4.
  - s_data/s_last ignored when s_valid=0.
  - Word completes on the 4th accepted byte, or on any byte with s_last=1. For a short final word, unused upper lanes are 0.
  - At that same edge: imem_we=1, imem_addr=word_cnt, imem_wdata=completed word; word_cnt increments and byte_cnt clears.
  - imem_we is high for exactly one cycle per word.
  - Back-to-back accepts allowed: a byte may be accepted on the edge that deasserts the previous strobe. Max throughput is 1 word per 4 cycles.
  - Completing word with s_last=1 -> HOLD; s_ready=0 from that edge.
  - Completing word at address 2^AW-1 without s_last -> ERROR; s_ready=0, err=1.
  - Word count exactly 2^AW with s_last on the final byte -> HOLD, no error.
- HOLD: core_reset=1; hold_cnt increments each cycle. After HOLD_CYCLES cycles following the final imem_we: -> RUN.
- RUN: core_reset=0, done=1, s_ready=0. Terminal until reset; stream input ignored.
- ERROR: err=1, core_reset=1, done=0, s_ready=0. Terminal until reset.
- Latency: final byte accept edge k -> imem_we high during cycle k..k+1 -> core_reset falls at edge k+HOLD_CYCLES.

Optional Feature:
- Macro: RV_IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - Adds input exp_checksum[31:0] and output checksum[31:0].
  - checksum resets to 0 and adds each written imem_wdata mod 2^32 at its write edge.
  - On HOLD exit: checksum==exp_checksum -> RUN; mismatch -> ERROR (err=1, core stays in reset).
- Undefined: neither port exists; HOLD always exits to RUN.

Test Plan:
- Bytes 13 05 50 00 (last on 4th) -> one imem_we, addr=0, wdata=0x00500513; core_reset falls 2 cycles after the strobe; done=1.
- 8 bytes 01..08, s_valid held high -> writes 0x04030201@0 and 0x08070605@1 exactly 4 cycles apart; s_ready=0 after the final accept.
- 5 bytes AA BB CC DD EE (last) -> 0xDDCCBBAA@0, then 0x000000EE@1.
- s_valid toggling 1/0 with random gaps -> identical writes to the gap-free run; no byte lost or duplicated.
- AW=2, 17 bytes, no s_last -> 4 writes (addr 0..3), then err=1, core_reset stays 1, s_ready=0.
- reset driven low mid-word after 2 bytes, then reload of 4 bytes -> first write at addr=0 with only the new bytes. With CHECKSUM_EN and a wrong exp_checksum -> err=1, done=0.
